// File: rtl/aes_ecb_sequencer_if.sv
// Request/result handshake bundle for the AES-256 ECB sequencer.
// s_*: key+plaintext request (valid/ready); m_*: ciphertext result (valid/ready).
interface aes_ecb_sequencer_if;
  logic         s_valid;
  logic         s_ready;
  logic [255:0] s_key;
  logic [127:0] s_plain;
  logic         s_rekey;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_cipher;

  modport slave (
    input  s_valid, s_key, s_plain, s_rekey,
    input  m_ready,
    output s_ready, m_valid, m_cipher
  );

  modport master (
    output s_valid, s_key, s_plain, s_rekey,
    output m_ready,
    input  s_ready, m_valid, m_cipher
  );
endinterface

// File: rtl/aes_ecb_sequencer.sv
// Front-end sequencer for the AES-256 ECB core: key stream, start pulse, result.
// Ports: clk, reset (sync, active-low), sq (request/result bundle), key_word,
// valid_word, start, plain_text, done, cipher_text, busy, err_timeout.
module aes_ecb_sequencer #(
  parameter int KEY_WORDS = 8,
  parameter int START_GAP = 2,
  parameter int START_LEN = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic         clk,
  input  logic         reset,
  aes_ecb_sequencer_if.slave sq,
  output logic [31:0]  key_word,
  output logic         valid_word,
  output logic         start,
  output logic [127:0] plain_text,
  input  logic         done,
  input  logic [127:0] cipher_text,
  output logic         busy,
  output logic         err_timeout
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] GAP  = 3'd2;
  localparam logic [2:0] STRT = 3'd3;
  localparam logic [2:0] WAIT = 3'd4;
  localparam logic [2:0] OUT  = 3'd5;

  localparam int CW = $clog2(TIMEOUT + KEY_WORDS
                     + START_GAP + START_LEN + 1);

  logic [2:0]    state;
  logic [2:0]    state_n;
  logic [2:0]    after_key;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [255:0]  key_reg;
  logic          key_loaded;
  logic          accept;

  assign accept = sq.s_valid && sq.s_ready;

  // A zero-length gap goes straight to the start pulse.
  assign after_key = (START_GAP == 0) ? STRT : GAP;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    unique case (state)
      IDLE: begin
        if (accept)
          state_n = (sq.s_rekey || !key_loaded)
                    ? LOAD : after_key;
      end
      LOAD: begin
        if (cnt == CW'(KEY_WORDS - 1))
          state_n = after_key;
      end
      GAP: begin
        if (cnt == CW'(START_GAP - 1))
          state_n = STRT;
      end
      STRT: begin
        if (cnt == CW'(START_LEN - 1))
          state_n = WAIT;
      end
      WAIT: begin
        if (done)
          state_n = OUT;
        else if (cnt == CW'(TIMEOUT - 1))
          state_n = IDLE;
      end
      OUT: begin
        if (sq.m_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Every state counts its own dwell from zero.
    if (state_n != state)
      cnt_n = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      key_reg     <= '0;
      key_loaded  <= 1'b0;
      key_word    <= '0;
      valid_word  <= 1'b0;
      start       <= 1'b0;
      plain_text  <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      sq.s_ready  <= 1'b0;
      sq.m_valid  <= 1'b0;
      sq.m_cipher <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      valid_word <= (state_n == LOAD);
      start      <= (state_n == STRT);
      busy       <= (state_n != IDLE);
      sq.s_ready <= (state_n == IDLE);
      sq.m_valid <= (state_n == OUT);
      key_word   <= '0;
      if (accept) begin
        plain_text <= sq.s_plain;
        key_reg    <= sq.s_key;
      end
      // Outputs are registered, so the word shown next
      // cycle comes from the request itself on accept.
      if (state_n == LOAD) begin
        if (accept) begin
          key_word <= sq.s_key[255:224];
          key_reg  <= {sq.s_key[223:0], 32'h0};
        end else begin
          key_word <= key_reg[255:224];
          key_reg  <= {key_reg[223:0], 32'h0};
        end
      end
      if (state == LOAD && state_n != LOAD)
        key_loaded <= 1'b1;
      if (state == WAIT && done)
        sq.m_cipher <= cipher_text;
      // The core may hold a partial key after an
      // abort, so force a reload next time.
      if (state == WAIT && state_n == IDLE) begin
        err_timeout <= 1'b1;
        key_loaded  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_aes_ecb_sequencer.sv
// Scoreboard bench for aes_ecb_sequencer with a behavioural core model.
// Directed FIPS/backpressure/timeout/reset/done-glitch cases plus random requests.
module tb_aes_ecb_sequencer;
  localparam int KW  = 8;
  localparam int G   = 2;
  localparam int L   = 2;
  localparam int TO  = 64;
  localparam int LAT = 5;
  localparam logic [255:0] FK =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  aes_ecb_sequencer_if sq_if ();
  logic [31:0]  key_word;
  logic         valid_word, start, done, busy, err_timeout;
  logic [127:0] plain_text;
  logic [127:0] cipher_text = '0;

  aes_ecb_sequencer #(
    .KEY_WORDS(KW), .START_GAP(G), .START_LEN(L), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .sq(sq_if),
    .key_word(key_word), .valid_word(valid_word), .start(start),
    .plain_text(plain_text), .done(done), .cipher_text(cipher_text),
    .busy(busy), .err_timeout(err_timeout)
  );

  typedef struct packed {
    logic [127:0] ct;
    logic [127:0] pt;
  } exp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int outs = 0;
  bit hold = 0;
  bit hang = 0;
  bit m_loaded = 0;
  logic [255:0] m_key = '0;
  logic done_inj = 1'b0;
  exp_t q[$];
  exp_t mon_e;
  logic [31:0] wlog[$];
  int wcyc[$];
  int scyc[$];

  // Stand-in for AES: the FIPS-197 C.3 vector, otherwise a keyed mix.
  function automatic logic [127:0] core_f(input logic [255:0] k,
                                          input logic [127:0] p);
    if (k == FK && p == FP) return FC;
    return k[255:128] ^ {k[63:0], k[127:64]} ^ {p[95:0], p[127:96]}
           ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    sq_if.m_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Core model: shifts in key words, answers LAT cycles after start rises.
  logic [255:0] core_key = '0;
  int core_cnt = 0;
  logic pstart = 1'b0;
  logic done_c = 1'b0;
  assign done = done_c | done_inj;

  always @(posedge clk) begin
    if (!reset) begin
      core_cnt <= 0;
      done_c   <= 1'b0;
      pstart   <= 1'b0;
    end else begin
      pstart <= start;
      done_c <= 1'b0;
      if (valid_word) core_key <= {core_key[223:0], key_word};
      if (start && !pstart && !hang) core_cnt <= LAT;
      else if (core_cnt != 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) begin
          done_c      <= 1'b1;
          cipher_text <= core_f(core_key, plain_text);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (valid_word) begin
        wlog.push_back(key_word);
        wcyc.push_back(cyc);
      end
      if (start) scyc.push_back(cyc);
      if (sq_if.m_valid && sq_if.m_ready) begin
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          mon_e = q.pop_front();
          chk("cipher", sq_if.m_cipher, mon_e.ct);
          chk("plain_hold", plain_text, mon_e.pt);
        end
        outs++;
      end
    end
  end

  task automatic do_req(input logic [255:0] k, input logic [127:0] p,
                        input bit rk, input bit hd);
    bit full;
    int c_acc, n0, t;
    exp_t e;
    full = rk || !m_loaded;
    if (full) begin
      m_key = k;
      m_loaded = 1;
    end
    e.ct = core_f(m_key, p);
    e.pt = p;
    if (!hang) q.push_back(e);
    t = 0;
    while (!sq_if.s_ready && t < 200) begin tick(); t++; end
    chk("s_ready_wait", sq_if.s_ready, 1);
    hold = hd;
    wlog.delete(); wcyc.delete(); scyc.delete();
    n0 = outs;
    sq_if.s_key = k;
    sq_if.s_plain = p;
    sq_if.s_rekey = rk;
    sq_if.s_valid = 1'b1;
    @(posedge clk);
    #1;
    c_acc = cyc;
    sq_if.s_valid = 1'b0;
    if (hang) begin
      t = 0;
      while (!err_timeout && t < TO + 100) begin tick(); t++; end
      chk("err_timeout_set", err_timeout, 1);
      chk("timeout_cycle", cyc, c_acc + (full ? KW : 0) + G + L + TO);
      chk("timeout_idle", busy, 0);
      tick();
      chk("timeout_no_out", outs - n0, 0);
      chk("timeout_m_valid", sq_if.m_valid, 0);
      m_loaded = 0;
      return;
    end
    if (hd) begin
      t = 0;
      while (!sq_if.m_valid && t < 200) begin tick(); t++; end
      for (int i = 0; i < 20; i++) begin
        tick();
        chk("hold_valid", sq_if.m_valid, 1);
        chk("hold_cipher", sq_if.m_cipher, e.ct);
        chk("hold_s_ready", sq_if.s_ready, 0);
        chk("hold_plain", plain_text, p);
        sq_if.s_valid = i[0];
        sq_if.s_key = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
        sq_if.s_plain = {$urandom, $urandom, $urandom, $urandom};
        sq_if.s_rekey = 1'b1;
      end
      sq_if.s_valid = 1'b0;
      hold = 0;
    end
    t = 0;
    while (outs == n0 && t < 500) begin tick(); t++; end
    chk("completed", outs - n0, 1);
    chk("n_words", wlog.size(), full ? KW : 0);
    for (int i = 0; i < wlog.size() && i < KW; i++) begin
      chk("word_val", wlog[i], k[255-32*i -: 32]);
      chk("word_cyc", wcyc[i], c_acc + i);
    end
    chk("n_start", scyc.size(), L);
    if (scyc.size() > 0)
      chk("start_cyc", scyc[0], c_acc + (full ? KW : 0) + G);
    if (scyc.size() == L)
      chk("start_last", scyc[L-1], scyc[0] + L - 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int t;
    sq_if.s_valid = 1'b0;
    sq_if.s_key = '0;
    sq_if.s_plain = '0;
    sq_if.s_rekey = 1'b0;
    repeat (3) tick();
    chk("rst_s_ready", sq_if.s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid_word", valid_word, 0);
    chk("rst_start", start, 0);
    chk("rst_m_valid", sq_if.m_valid, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_key_word", key_word, 0);
    reset = 1'b1;
    tick();
    chk("post_rst_s_ready", sq_if.s_ready, 1);
    chk("post_rst_busy", busy, 0);

    done_inj = 1'b1;
    tick();
    done_inj = 1'b0;
    tick();
    chk("idle_done_busy", busy, 0);
    chk("idle_done_m_valid", sq_if.m_valid, 0);
    chk("idle_done_s_ready", sq_if.s_ready, 1);

    do_req(FK, FP, 1, 0);
    do_req(FK, FP, 0, 0);
    do_req({$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, 1, 1);

    hang = 1;
    do_req(FK, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    hang = 0;
    do_req({$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, 0, 0);

    t = 0;
    while (!sq_if.s_ready && t < 200) begin tick(); t++; end
    wlog.delete(); wcyc.delete(); scyc.delete();
    sq_if.s_key = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
    sq_if.s_rekey = 1'b1;
    sq_if.s_valid = 1'b1;
    @(posedge clk);
    #1;
    sq_if.s_valid = 1'b0;
    t = 0;
    while (wlog.size() < 3 && t < 50) begin tick(); t++; end
    reset = 1'b0;
    tick();
    chk("midrst_valid_word", valid_word, 0);
    chk("midrst_start", start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_m_valid", sq_if.m_valid, 0);
    chk("midrst_err", err_timeout, 0);
    reset = 1'b1;
    m_loaded = 0;
    tick();
    do_req({$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, 0, 0);

    fork
      do_req({$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 1, 0);
      begin
        int t2;
        t2 = 0;
        while (!valid_word && t2 < 100) begin tick(); t2++; end
        done_inj = 1'b1;
        tick();
        done_inj = 1'b0;
      end
    join

    for (int n = 0; n < 25; n++)
      do_req({$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom},
             1'($urandom_range(0, 1)), 0);

    repeat (5) tick();
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
